// File: rtl/timer_pkg.sv
// Shared register map offsets and TCON bit positions for the timer peripheral.
package timer_pkg;

    localparam logic [31:0] OFF_TH      = 32'd0;
    localparam logic [31:0] OFF_TL      = 32'd4;
    localparam logic [31:0] OFF_TCON    = 32'd8;
    localparam logic [31:0] OFF_SYSTICK = 32'd12;

    localparam int TCON_EN    = 0;
    localparam int TCON_IRQEN = 1;
    localparam int TCON_IRQ   = 2;
    localparam int TCON_W     = 3;

    // Word-granular match: the two byte-lane bits never take part in decode.
    function automatic logic addr_hit(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] off);
        logic [31:0] reg_addr;
        reg_addr = base + off;
        return addr[31:2] == reg_addr[31:2];
    endfunction

endpackage

// File: rtl/timer_counter.sv
// TL counter with reload-from-TH on wrap, and the TCON register whose irq bit
// is set by that wrap. Bus writes take precedence over counting and irq-set.
module timer_counter
    import timer_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       th,
    input  logic              tl_we,
    input  logic              tcon_we,
    input  logic [31:0]       wdata,
    output logic [31:0]       tl,
    output logic [TCON_W-1:0] tcon
);

    logic overflow;

    // A TL write on the wrap edge pre-empts the wrap entirely: no reload, no irq.
    assign overflow = tcon[TCON_EN] && (tl == 32'hFFFF_FFFF) && !tl_we;

    always_ff @(posedge clk) begin
        if (reset) begin
            tl   <= '0;
            tcon <= '0;
        end else begin
            if (tl_we) begin
                tl <= wdata;
            end else if (tcon[TCON_EN]) begin
                tl <= overflow ? th : tl + 32'd1;
            end

            if (tcon_we) begin
                tcon <= wdata[TCON_W-1:0];
            end else if (overflow && tcon[TCON_IRQEN]) begin
                tcon[TCON_IRQ] <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/timer_peripheral.sv
// Memory-mapped timer: TH reload, TL counter, TCON control/status, irq output.
// Define TIMER_SYSTICK_EN to add the read-only free-running SYSTICK register.
module timer_peripheral
    import timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        irq
);

    // Bus semantics: MemWrite with an address hit commits on the edge it is
    // sampled; MemRead with a hit returns the pre-edge register value on
    // ReadData after that edge, and ReadData is 0 on every other cycle.

    logic              hit_th;
    logic              hit_tl;
    logic              hit_tcon;
    logic [31:0]       th;
    logic [31:0]       tl;
    logic [TCON_W-1:0] tcon;
    logic [31:0]       rd_mux;
    logic              unused_addr_lsb;

    assign unused_addr_lsb = ^Address[1:0];

    assign hit_th   = addr_hit(Address, BASE_ADDR, OFF_TH);
    assign hit_tl   = addr_hit(Address, BASE_ADDR, OFF_TL);
    assign hit_tcon = addr_hit(Address, BASE_ADDR, OFF_TCON);

`ifdef TIMER_SYSTICK_EN
    logic        hit_systick;
    logic [31:0] systick;

    assign hit_systick = addr_hit(Address, BASE_ADDR, OFF_SYSTICK);

    // Counts every cycle out of reset; bus writes are deliberately not decoded.
    always_ff @(posedge clk) begin
        if (reset) begin
            systick <= '0;
        end else begin
            systick <= systick + 32'd1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            th <= '0;
        end else if (MemWrite && hit_th) begin
            th <= WriteData;
        end
    end

    timer_counter u_counter (
        .clk     (clk),
        .reset   (reset),
        .th      (th),
        .tl_we   (MemWrite && hit_tl),
        .tcon_we (MemWrite && hit_tcon),
        .wdata   (WriteData),
        .tl      (tl),
        .tcon    (tcon)
    );

    always_comb begin
        rd_mux = '0;
        if (hit_th) begin
            rd_mux = th;
        end else if (hit_tl) begin
            rd_mux = tl;
        end else if (hit_tcon) begin
            rd_mux = {{(32-TCON_W){1'b0}}, tcon};
`ifdef TIMER_SYSTICK_EN
        end else if (hit_systick) begin
            rd_mux = systick;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ReadData <= '0;
        end else begin
            ReadData <= MemRead ? rd_mux : 32'd0;
        end
    end

    assign irq = tcon[TCON_IRQ];

endmodule

// File: tb/tb_timer_peripheral.sv
// Directed bench for timer_peripheral: register-level model plus literal read expectations.
module tb_timer_peripheral;

    localparam logic [31:0] BASE   = 32'h4000_0000;
    localparam logic [31:0] A_TH   = BASE;
    localparam logic [31:0] A_TL   = BASE + 32'd4;
    localparam logic [31:0] A_TCON = BASE + 32'd8;
    localparam logic [31:0] A_SYS  = BASE + 32'd12;
    localparam logic [31:0] A_HOLE = BASE + 32'd16;
    localparam logic [31:0] MAXV   = 32'hFFFF_FFFF;
`ifdef TIMER_SYSTICK_EN
    localparam bit HAS_SYS = 1'b1;
`else
    localparam bit HAS_SYS = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        irq;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    timer_peripheral #(.BASE_ADDR(BASE)) dut (
        .clk       (clk),
        .reset     (reset),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .Address   (Address),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .irq       (irq)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [31:0] m_th, m_tl, m_sys, m_rdata;
    logic [2:0]  m_tcon;
    bit          m_valid  = 1'b0;
    bit          m_rd_due = 1'b0;

    function automatic bit same_word(input logic [31:0] a, input logic [31:0] b);
        return a[31:2] == b[31:2];
    endfunction

    // TL next value: bus write wins, else hold when disabled, else wrap to TH or count.
    function automatic logic [31:0] next_tl(input logic [31:0] tl, input logic [31:0] th,
                                            input logic [2:0] tcon, input bit tl_wr,
                                            input logic [31:0] wd);
        if (tl_wr) return wd;
        if (!tcon[0]) return tl;
        if (tl == MAXV) return th;
        return tl + 32'd1;
    endfunction

    function automatic logic [2:0] next_tcon(input logic [2:0] tcon, input logic [31:0] tl,
                                             input bit tcon_wr, input bit tl_wr,
                                             input logic [31:0] wd);
        if (tcon_wr) return wd[2:0];
        if (tcon[0] && tcon[1] && tl == MAXV && !tl_wr) return tcon | 3'b100;
        return tcon;
    endfunction

    function automatic logic [31:0] read_val(input logic [31:0] a);
        if (same_word(a, A_TH))   return m_th;
        if (same_word(a, A_TL))   return m_tl;
        if (same_word(a, A_TCON)) return {29'd0, m_tcon};
        if (HAS_SYS && same_word(a, A_SYS)) return m_sys;
        return 32'd0;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_th     <= 32'd0;
            m_tl     <= 32'd0;
            m_tcon   <= 3'd0;
            m_sys    <= 32'd0;
            m_rdata  <= 32'd0;
            m_rd_due <= 1'b0;
            m_valid  <= 1'b1;
        end else begin
            m_rd_due <= MemRead;
            m_rdata  <= MemRead ? read_val(Address) : 32'd0;
            m_tl     <= next_tl(m_tl, m_th, m_tcon, MemWrite && same_word(Address, A_TL), WriteData);
            m_tcon   <= next_tcon(m_tcon, m_tl, MemWrite && same_word(Address, A_TCON),
                                  MemWrite && same_word(Address, A_TL), WriteData);
            if (MemWrite && same_word(Address, A_TH)) m_th <= WriteData;
            m_sys    <= m_sys + 32'd1;
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            check("readdata_model", ReadData, m_rdata);
            check("irq_model", {31'd0, irq}, {31'd0, m_tcon[2]});
            if (m_rd_due) begin
                if (exp_q.size() == 0) begin
                    check("exp_q_underflow", 32'd1, 32'd0);
                end else begin
                    check("read_literal", ReadData, exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        MemWrite = 1'b1; Address = a; WriteData = d;
        step();
        MemWrite = 1'b0; Address = 32'd0; WriteData = 32'd0;
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] exp);
        MemRead = 1'b1; Address = a;
        exp_q.push_back(exp);
        step();
        MemRead = 1'b0; Address = 32'd0;
    endtask

    task automatic do_rw(input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp);
        MemRead = 1'b1; MemWrite = 1'b1; Address = a; WriteData = d;
        exp_q.push_back(exp);
        step();
        MemRead = 1'b0; MemWrite = 1'b0; Address = 32'd0; WriteData = 32'd0;
    endtask

    // Reset for one edge while the bus is busy, to show reset overrides it.
    task automatic do_reset_busy();
        reset = 1'b1; MemRead = 1'b1; MemWrite = 1'b1; Address = A_TCON; WriteData = 32'd7;
        step();
        reset = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; Address = 32'd0; WriteData = 32'd0;
    endtask

    task automatic check_irq(input string name, input logic exp);
        check(name, {31'd0, irq}, {31'd0, exp});
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; Address = 32'd0; WriteData = 32'd0;
        idle(2);
        reset = 1'b0;
        check("reset_readdata", ReadData, 32'd0);
        check_irq("reset_irq", 1'b0);

        // Overflow with irq enabled: FFFF_FFFE -> FFFF_FFFF -> reload FFFF_FFFC.
        do_write(A_TH, 32'hFFFF_FFFC);
        do_write(A_TL, 32'hFFFF_FFFE);
        do_write(A_TCON, 32'd3);
        do_read(A_TL, 32'hFFFF_FFFE);
        check_irq("irq_before_wrap", 1'b0);
        do_read(A_TL, 32'hFFFF_FFFF);
        check_irq("irq_on_wrap_edge", 1'b1);
        do_read(A_TL, 32'hFFFF_FFFC);
        do_read(A_TCON, 32'd7);

        // Software clears irq; counting carries on FD, FE, FF, then wraps again.
        do_write(A_TCON, 32'd3);
        check_irq("irq_cleared", 1'b0);
        do_read(A_TL, 32'hFFFF_FFFF);
        check_irq("irq_second_wrap", 1'b1);

        // TCON write with bit2=0 on the wrap edge: irq cleared, set suppressed.
        idle(3);
        do_write(A_TCON, 32'd1);
        check_irq("irq_concurrent_clear", 1'b0);

        // irq_en=0 through another wrap: reload happens, irq stays low.
        idle(4);
        check_irq("irq_en_off", 1'b0);
        do_read(A_TCON, 32'd1);
        do_read(A_TL, 32'hFFFF_FFFD);

        // TL write on the wrap edge beats reload and irq-set.
        do_write(A_TCON, 32'd3);
        do_write(A_TL, 32'd5);
        check_irq("tl_write_on_wrap", 1'b0);
        do_read(A_TL, 32'd5);

        // Read+write same register returns old value; lane bits ignored; holes inert.
        do_rw(A_TH, 32'h1234_5678, 32'hFFFF_FFFC);
        do_read(A_TH, 32'h1234_5678);
        do_read(A_TH + 32'd2, 32'h1234_5678);
        do_write(A_HOLE, 32'hFFFF_FFFF);
        do_write(BASE - 32'd4, 32'hFFFF_FFFF);
        do_read(A_TH, 32'h1234_5678);
        do_read(A_TCON, 32'd3);
        do_read(A_HOLE, 32'd0);
        do_write(A_TCON, 32'hFFFF_FFFB);
        do_read(A_TCON, 32'd3);

        // Force irq high, then reset mid-count with the bus active.
        do_write(A_TL, MAXV);
        idle(1);
        check_irq("irq_before_reset", 1'b1);
        do_reset_busy();
        check_irq("irq_after_reset", 1'b0);
        check("readdata_after_reset", ReadData, 32'd0);
        do_read(A_TH, 32'd0);
        do_read(A_TL, 32'd0);
        do_read(A_TCON, 32'd0);
        do_read(A_HOLE, 32'd0);

        // SYSTICK: four edges since reset before this read's edge.
        do_read(A_SYS, HAS_SYS ? 32'd4 : 32'd0);
        do_write(A_SYS, 32'hDEAD_BEEF);
        do_read(A_SYS, HAS_SYS ? 32'd6 : 32'd0);

        idle(2);
        check("exp_q_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
